// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared encodings for the pattern-RAM Wishbone arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE = 2'd0;
   localparam logic [1:0] ARB_CPU  = 2'd1;
   localparam logic [1:0] ARB_GEN  = 2'd2;

   // CPU window is 1 KiB: the upper address bits above this width select it
   localparam int WIN_W = 10;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_CPU  = 2'b01;
   localparam logic [1:0] GRANT_GEN  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = ARB_IDLE,
      ST_CPU  = ARB_CPU,
      ST_GEN  = ARB_GEN
   } arb_state_e;

   typedef enum logic {
      M_CPU = 1'b0,
      M_GEN = 1'b1
   } master_e;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_timeout.sv
// ============================================================================
// ram_arbiter_timeout : loadable down-counter flagging a missing RAM ack
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_arbiter_timeout #(
   parameter logic [7:0] TIMEOUT = 8'd32
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   input  logic active_i,
   input  logic ack_i,
   output logic expired_o
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = TIMEOUT;
      end else if (active_i && !ack_i && (count_q != 8'd0)) begin
         count_d = count_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // A zero TIMEOUT loads 0, which never matches 1, so expiry is disabled
   assign expired_o = active_i && !ack_i && (count_q == 8'd1) && (TIMEOUT != 8'd0);

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : round-robin Wishbone arbiter, CPU + generator onto pattern RAM
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0400,
   parameter logic [7:0]  TIMEOUT      = 8'd32
) (
   input  logic        caravel_wb_clk_i,
   input  logic        caravel_wb_rst_n_i,
   input  logic        caravel_wb_stb_i,
   input  logic        caravel_wb_cyc_i,
   input  logic        caravel_wb_we_i,
   input  logic [3:0]  caravel_wb_sel_i,
   input  logic [31:0] caravel_wb_dat_i,
   input  logic [31:0] caravel_wb_adr_i,
   output logic        caravel_wb_ack_o,
   output logic        caravel_wb_err_o,
   output logic [31:0] caravel_wb_dat_o,
   input  logic        gen_wb_stb_i,
   input  logic        gen_wb_cyc_i,
   input  logic [7:0]  gen_wb_adr_i,
   output logic        gen_wb_ack_o,
   output logic        gen_wb_err_o,
   output logic [31:0] gen_wb_dat_o,
   output logic        ram_wb_stb_o,
   output logic        ram_wb_cyc_o,
   output logic        ram_wb_we_o,
   output logic [3:0]  ram_wb_sel_o,
   output logic [31:0] ram_wb_dat_o,
   output logic [7:0]  ram_wb_adr_o,
   input  logic        ram_wb_ack_i,
   input  logic [31:0] ram_wb_dat_i,
   output logic [1:0]  grant_o
);

   arb_state_e  state_q,      state_d;
   master_e     last_grant_q, last_grant_d;
   logic        ram_act_q,    ram_act_d;
   logic        ram_we_q,     ram_we_d;
   logic [3:0]  ram_sel_q,    ram_sel_d;
   logic [31:0] ram_dat_q,    ram_dat_d;
   logic [7:0]  ram_adr_q,    ram_adr_d;
   logic        cpu_ack_q,    cpu_ack_d;
   logic        cpu_err_q,    cpu_err_d;
   logic [31:0] cpu_dat_q,    cpu_dat_d;
   logic        gen_ack_q,    gen_ack_d;
   logic        gen_err_q,    gen_err_d;
   logic [31:0] gen_dat_q,    gen_dat_d;

   logic cpu_hit;
   logic cpu_req;
   logic gen_req;
   logic tmo_load;
   logic tmo_expired;
   logic unused_adr_bits;

   assign unused_adr_bits = ^caravel_wb_adr_i[1:0];

   assign cpu_hit = (caravel_wb_adr_i[31:WIN_W] == BASE_ADDRESS[31:WIN_W]);

   // A master still showing ack/err this cycle has not yet seen its completion,
   // so its strobe is stale and must not win a new grant.
   assign cpu_req = caravel_wb_stb_i && caravel_wb_cyc_i && cpu_hit && !(cpu_ack_q || cpu_err_q);
   assign gen_req = gen_wb_stb_i && gen_wb_cyc_i && !(gen_ack_q || gen_err_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      ram_act_d    = ram_act_q;
      ram_we_d     = ram_we_q;
      ram_sel_d    = ram_sel_q;
      ram_dat_d    = ram_dat_q;
      ram_adr_d    = ram_adr_q;
      cpu_ack_d    = 1'b0;
      cpu_err_d    = 1'b0;
      cpu_dat_d    = cpu_dat_q;
      gen_ack_d    = 1'b0;
      gen_err_d    = 1'b0;
      gen_dat_d    = gen_dat_q;
      tmo_load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req && (!gen_req || (last_grant_q == M_GEN))) begin
               state_d      = ST_CPU;
               last_grant_d = M_CPU;
               ram_act_d    = 1'b1;
               ram_we_d     = caravel_wb_we_i;
               ram_sel_d    = caravel_wb_sel_i;
               ram_dat_d    = caravel_wb_dat_i;
               ram_adr_d    = caravel_wb_adr_i[WIN_W-1:2];
               tmo_load     = 1'b1;
            end else if (gen_req) begin
               state_d      = ST_GEN;
               last_grant_d = M_GEN;
               ram_act_d    = 1'b1;
               ram_we_d     = 1'b0;
               ram_sel_d    = 4'b1111;
               ram_dat_d    = 32'd0;
               ram_adr_d    = gen_wb_adr_i;
               tmo_load     = 1'b1;
            end
         end
         ST_CPU, ST_GEN: begin
            if (ram_wb_ack_i) begin
               state_d   = ST_IDLE;
               ram_act_d = 1'b0;
               if (state_q == ST_CPU) begin
                  cpu_ack_d = 1'b1;
                  cpu_dat_d = ram_wb_dat_i;
               end else begin
                  gen_ack_d = 1'b1;
                  gen_dat_d = ram_wb_dat_i;
               end
            end else if (tmo_expired) begin
               state_d   = ST_IDLE;
               ram_act_d = 1'b0;
               if (state_q == ST_CPU) begin
                  cpu_err_d = 1'b1;
               end else begin
                  gen_err_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
      if (!caravel_wb_rst_n_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= M_CPU;
         ram_act_q    <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_sel_q    <= 4'd0;
         ram_dat_q    <= 32'd0;
         ram_adr_q    <= 8'd0;
         cpu_ack_q    <= 1'b0;
         cpu_err_q    <= 1'b0;
         cpu_dat_q    <= 32'd0;
         gen_ack_q    <= 1'b0;
         gen_err_q    <= 1'b0;
         gen_dat_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         ram_act_q    <= ram_act_d;
         ram_we_q     <= ram_we_d;
         ram_sel_q    <= ram_sel_d;
         ram_dat_q    <= ram_dat_d;
         ram_adr_q    <= ram_adr_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_err_q    <= cpu_err_d;
         cpu_dat_q    <= cpu_dat_d;
         gen_ack_q    <= gen_ack_d;
         gen_err_q    <= gen_err_d;
         gen_dat_q    <= gen_dat_d;
      end
   end

   ram_arbiter_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (caravel_wb_clk_i),
      .rst_n_i   (caravel_wb_rst_n_i),
      .load_i    (tmo_load),
      .active_i  (state_q != ST_IDLE),
      .ack_i     (ram_wb_ack_i),
      .expired_o (tmo_expired)
   );

   assign ram_wb_cyc_o     = ram_act_q;
   assign ram_wb_stb_o     = ram_act_q;
   assign ram_wb_we_o      = ram_we_q;
   assign ram_wb_sel_o     = ram_sel_q;
   assign ram_wb_dat_o     = ram_dat_q;
   assign ram_wb_adr_o     = ram_adr_q;
   assign caravel_wb_ack_o = cpu_ack_q;
   assign caravel_wb_err_o = cpu_err_q;
   assign caravel_wb_dat_o = cpu_dat_q;
   assign gen_wb_ack_o     = gen_ack_q;
   assign gen_wb_err_o     = gen_err_q;
   assign gen_wb_dat_o     = gen_dat_q;
   assign grant_o          = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : self-checking bench with a behavioural RAM and shadow memory
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

   localparam logic [21:0] BASE_HI = 22'h0C0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        c_stb = 1'b0, c_cyc = 1'b0, c_we = 1'b0;
   logic [3:0]  c_sel = 4'd0;
   logic [31:0] c_wdat = 32'd0, c_adr = 32'd0;
   logic        c_ack, c_err;
   logic [31:0] c_rdat;
   logic        g_stb = 1'b0, g_cyc = 1'b0;
   logic [7:0]  g_adr = 8'd0;
   logic        g_ack, g_err;
   logic [31:0] g_rdat;
   logic        ram_stb, ram_cyc, ram_we;
   logic [3:0]  ram_sel;
   logic [31:0] ram_wdat;
   logic [7:0]  ram_adr;
   logic        ram_ack;
   logic [31:0] ram_rdat;
   logic [1:0]  grant;

   logic        ram_ready = 1'b0;
   logic        mem_clear = 1'b0;
   logic [31:0] ram_mem   [256];
   logic [31:0] model_mem [256];

   int n_assert = 0;
   int n_fail   = 0;
   int cpu_ack_n = 0, cpu_err_n = 0, gen_ack_n = 0, gen_err_n = 0;
   logic [31:0] exp_cdat = 32'd0, exp_gdat = 32'd0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .caravel_wb_clk_i   (clk),
      .caravel_wb_rst_n_i (rst_n),
      .caravel_wb_stb_i   (c_stb),
      .caravel_wb_cyc_i   (c_cyc),
      .caravel_wb_we_i    (c_we),
      .caravel_wb_sel_i   (c_sel),
      .caravel_wb_dat_i   (c_wdat),
      .caravel_wb_adr_i   (c_adr),
      .caravel_wb_ack_o   (c_ack),
      .caravel_wb_err_o   (c_err),
      .caravel_wb_dat_o   (c_rdat),
      .gen_wb_stb_i       (g_stb),
      .gen_wb_cyc_i       (g_cyc),
      .gen_wb_adr_i       (g_adr),
      .gen_wb_ack_o       (g_ack),
      .gen_wb_err_o       (g_err),
      .gen_wb_dat_o       (g_rdat),
      .ram_wb_stb_o       (ram_stb),
      .ram_wb_cyc_o       (ram_cyc),
      .ram_wb_we_o        (ram_we),
      .ram_wb_sel_o       (ram_sel),
      .ram_wb_dat_o       (ram_wdat),
      .ram_wb_adr_o       (ram_adr),
      .ram_wb_ack_i       (ram_ack),
      .ram_wb_dat_i       (ram_rdat),
      .grant_o            (grant)
   );

   // Behavioural RAM: acks combinationally on stb whenever the bench allows it
   assign ram_ack  = ram_cyc && ram_stb && ram_ready;
   assign ram_rdat = ram_mem[ram_adr];

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= 32'd0;
      end else if (ram_ack && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_sel[b]) ram_mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
      end
   end

   always @(negedge clk) begin
      if (c_ack) cpu_ack_n++;
      if (c_err) cpu_err_n++;
      if (g_ack) gen_ack_n++;
      if (g_err) gen_err_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_ctl"}, 32'({c_ack, c_err, g_ack, g_err, ram_cyc, ram_stb, ram_we, ram_sel, grant, ram_adr}), 32'd0);
      chk({tag, "_cdat"}, c_rdat, 32'd0);
      chk({tag, "_gdat"}, g_rdat, 32'd0);
      chk({tag, "_wdat"}, ram_wdat, 32'd0);
   endtask

   // One complete transaction; the RAM withholds ack for 'delay' cycles
   task automatic do_txn(input bit gen, input bit we, input logic [7:0] a,
                         input logic [3:0] sel, input logic [31:0] d, input int delay);
      logic [31:0] old;
      old = model_mem[a];
      if (gen) begin
         g_stb = 1'b1; g_cyc = 1'b1; g_adr = a;
      end else begin
         c_stb = 1'b1; c_cyc = 1'b1; c_we = we; c_sel = sel; c_wdat = d;
         c_adr = {BASE_HI, a, 2'($urandom)};
      end
      ram_ready = (delay == 0);
      tick();
      chk("txn_grant", 32'(grant), gen ? 32'd2 : 32'd1);
      chk("txn_rambus", 32'({ram_cyc, ram_stb, ram_we, ram_sel, ram_adr}),
          32'({1'b1, 1'b1, (gen ? 1'b0 : we), (gen ? 4'hF : sel), a}));
      if (!gen && we) chk("txn_wdat", ram_wdat, d);
      for (int k = 1; k <= delay; k++) begin
         tick();
         chk("txn_wait", 32'({c_ack, g_ack, ram_stb}), 32'd1);
         if (k == delay) ram_ready = 1'b1;
      end
      tick();
      if (gen) exp_gdat = old; else exp_cdat = old;
      chk("txn_ack", 32'({c_ack, g_ack, c_err, g_err}), gen ? 32'b0100 : 32'b1000);
      chk("txn_done", 32'({ram_cyc, ram_stb, grant}), 32'd0);
      chk("txn_cdat", c_rdat, exp_cdat);
      chk("txn_gdat", g_rdat, exp_gdat);
      if (!gen && we)
         for (int b = 0; b < 4; b++)
            if (sel[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
      if (gen) begin
         g_stb = 1'b0; g_cyc = 1'b0;
      end else begin
         c_stb = 1'b0; c_cyc = 1'b0; c_we = 1'b0;
      end
      ram_ready = 1'b0;
      tick();
      chk("txn_pulse", 32'({c_ack, g_ack}), 32'd0);
   endtask

   initial begin
      int e0, a0, g0, gseen;
      logic [1:0] prev, expg;

      // Reset state
      for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
      mem_clear = 1'b1;
      tick();
      tick();
      outputs_zero("reset");
      mem_clear = 1'b0;
      rst_n = 1'b1;
      tick();

      // Directed CPU write then generator read-back
      do_txn(1'b0, 1'b1, 8'h02, 4'hF, 32'hA5A5_0001, 0);
      do_txn(1'b1, 1'b0, 8'h02, 4'h0, 32'd0, 0);
      chk("gen_readback", g_rdat, 32'hA5A5_0001);

      // Random single-master traffic against the shadow memory
      for (int t = 0; t < 24; t++) begin
         do_txn(1'($urandom), 1'($urandom), 8'($urandom_range(0, 7)), 4'($urandom),
                $urandom, $urandom_range(0, 3));
      end

      // Timeout: RAM never acks
      e0 = cpu_err_n;
      ram_ready = 1'b0;
      c_stb = 1'b1; c_cyc = 1'b1; c_we = 1'b0; c_sel = 4'hF; c_adr = {BASE_HI, 8'h05, 2'b00};
      tick();
      chk("to_stb", 32'(ram_stb), 32'd1);
      for (int k = 1; k <= 31; k++) tick();
      chk("to_early", 32'({c_err, c_ack, ram_stb}), 32'b001);
      tick();
      chk("to_err", 32'({c_err, c_ack, ram_cyc, grant}), 32'b10000);
      c_stb = 1'b0; c_cyc = 1'b0;
      tick();
      chk("to_once", 32'(cpu_err_n - e0), 32'd1);
      chk("to_cdat", c_rdat, exp_cdat);
      do_txn(1'b0, 1'b0, 8'h05, 4'hF, 32'd0, 1);

      // Out-of-window CPU access, alone and alongside the generator
      a0 = cpu_ack_n;
      c_stb = 1'b1; c_cyc = 1'b1; c_we = 1'($urandom); c_sel = 4'hF; c_adr = 32'h3000_0000;
      ram_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("oow_idle", 32'({ram_cyc, ram_stb, grant}), 32'd0);
      do_txn(1'b1, 1'b0, 8'h03, 4'h0, 32'd0, 0);
      chk("oow_noack", 32'(cpu_ack_n - a0), 32'd0);
      c_stb = 1'b0; c_cyc = 1'b0; c_we = 1'b0;

      // Asynchronous reset in the middle of a generator transaction
      g_stb = 1'b1; g_cyc = 1'b1; g_adr = 8'h02;
      ram_ready = 1'b0;
      tick();
      chk("rst_busgen", 32'(grant), 32'd2);
      #2 rst_n = 1'b0;
      #1 outputs_zero("async_rst");
      g_stb = 1'b0; g_cyc = 1'b0;
      exp_cdat = 32'd0; exp_gdat = 32'd0;
      tick();
      rst_n = 1'b1;
      a0 = cpu_ack_n + cpu_err_n;
      g0 = gen_ack_n + gen_err_n;
      for (int k = 0; k < 40; k++) tick();
      chk("rst_no_cpl", 32'((cpu_ack_n + cpu_err_n - a0) + (gen_ack_n + gen_err_n - g0)), 32'd0);

      // Contention: alternation starting with the generator
      c_stb = 1'b1; c_cyc = 1'b1; c_we = 1'b0; c_sel = 4'hF; c_adr = {BASE_HI, 8'h01, 2'b00};
      g_stb = 1'b1; g_cyc = 1'b1; g_adr = 8'h04;
      expg = 2'b10;
      prev = 2'b00;
      gseen = 0;
      for (int cyc = 0; cyc < 400 && gseen < 8; cyc++) begin
         tick();
         ram_ready = 1'($urandom);
         if (grant != 2'b00 && prev == 2'b00) begin
            chk("tie_grant", 32'(grant), 32'(expg));
            expg = (expg == 2'b10) ? 2'b01 : 2'b10;
            gseen++;
         end
         prev = grant;
      end
      chk("tie_count", 32'(gseen), 32'd8);
      c_stb = 1'b0; c_cyc = 1'b0; g_stb = 1'b0; g_cyc = 1'b0;
      ram_ready = 1'b1;
      for (int k = 0; k < 4; k++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single 8-bit-addressed pattern RAM bus between the Caravel CPU and the waveform generator.
  - CPU port (master 0) loads and reads back pattern words.
  - Generator port (master 1) fetches 32-bit words for DAC playback.
- Round-robin arbitration, one outstanding transaction at a time.
- Per-transaction ack timeout with an error return.
- Sits between caravel_wb, the generator's rambus master, and the RAM.

Parameters:
BASE_ADDRESS, 32'h3000_0400, CPU window base; 1 KiB window (256 words).
TIMEOUT, 8'd32, max cycles to wait for ram_wb_ack_i; 0 disables the timeout.

Ports:
caravel_wb_clk_i  input  1  system clock, single clock domain
caravel_wb_rst_n_i  input  1  asynchronous active-low reset
caravel_wb_stb_i  input  1  CPU strobe
caravel_wb_cyc_i  input  1  CPU cycle
caravel_wb_we_i  input  1  CPU write enable
caravel_wb_sel_i  input  4  CPU byte select
caravel_wb_dat_i  input  32  CPU write data
caravel_wb_adr_i  input  32  CPU byte address
caravel_wb_ack_o  output  1  CPU ack, 1-cycle pulse
caravel_wb_err_o  output  1  CPU timeout error, 1-cycle pulse
caravel_wb_dat_o  output  32  CPU read data
gen_wb_stb_i  input  1  generator strobe (read-only master)
gen_wb_cyc_i  input  1  generator cycle
gen_wb_adr_i  input  8  generator word address
gen_wb_ack_o  output  1  generator ack, 1-cycle pulse
gen_wb_err_o  output  1  generator timeout error, 1-cycle pulse
gen_wb_dat_o  output  32  generator read data
ram_wb_stb_o  output  1  RAM strobe
ram_wb_cyc_o  output  1  RAM cycle
ram_wb_we_o  output  1  RAM write enable
ram_wb_sel_o  output  4  RAM byte select
ram_wb_dat_o  output  32  RAM write data
ram_wb_adr_o  output  8  RAM word address
ram_wb_ack_i  input  1  RAM ack
ram_wb_dat_i  input  32  RAM read data
grant_o  output  2  debug: 00 idle, 01 CPU, 10 generator

Behaviour:

Reset:
- caravel_wb_rst_n_i low immediately clears all outputs and state to 0.
- Exceptions: last_grant resets to CPU; timeout counter resets to 0.
- Reset mid-transaction abandons it: no ack and no err are issued.

Requests:
- cpu_req = stb & cyc & (adr[31:10] == BASE_ADDRESS[31:10]).
- gen_req = stb & cyc.
- CPU accesses outside the window are ignored: never acked.

FSM states: IDLE, BUS_CPU, BUS_GEN.
- IDLE, one requester: grant it.
- IDLE, both requesting: grant the master not in last_grant; last_grant is updated on every grant.
- Tie-break after reset: generator wins the first tie.
- Grant edge: registers ram_cyc_o = ram_stb_o = 1, plus adr, we, sel and dat from the winner. RAM stb rises 1 cycle after the request is first visible.
- CPU address mapping: ram_wb_adr_o = caravel_wb_adr_i[9:2].
- Generator fixed fields: we = 0, sel = 4'b1111, dat = 0.
- BUS_x, on ram_wb_ack_i:
  - drop ram cyc/stb;
  - pulse the granted master's ack_o for 1 cycle;
  - register ram_wb_dat_i into that master's dat_o (reads and writes alike);
  - go to IDLE.
- Other master's dat_o holds its last value.
- Timeout:
  - Counter loads TIMEOUT on grant and decrements each BUS_x cycle without ack.
  - Counter reaches 1 with no ack: drop ram cyc/stb, pulse the master's err_o instead of ack_o, go to IDLE.
  - Ack and expiry in the same cycle: ack wins.
- Re-grant masking: in IDLE, a master whose ack_o or err_o is high this cycle is masked. This prevents re-granting a stale strobe before the master has dropped it.
- Master dropping cyc while granted: transaction still completes on the RAM side; ack is still pulsed and is ignored by the master.
- Master-visible latency for a RAM acking combinationally on stb: request cycle N, RAM stb at N+1, ack_o at N+2.
- grant_o mirrors the FSM state.

Decomposition:
- Shared package holds:
  - state encoding localparams (ARB_IDLE = 0, ARB_CPU = 1, ARB_GEN = 2);
  - the window-width constant (10);
  - grant_o codes.
- One natural sub-module, ram_arbiter_timeout: loadable down-counter with load/ack/expired ports.
- The arbiter FSM and datapath muxes stay in the top module.

Test Plan:
- CPU write 0x3000_0408 = 0xA5A5_0001, sel 1111, RAM acks next cycle -> ram adr 0x02, we = 1, dat 0xA5A5_0001; caravel ack pulse at N+2; grant_o = 01 during the transaction.
- Generator read adr 0x02 -> gen_wb_dat_o = 0xA5A5_0001, gen ack 1 cycle, ram_we = 0, sel = 1111.
- CPU and generator both request every cycle -> grants alternate GEN, CPU, GEN, CPU, starting with GEN after reset; no master ever receives two consecutive grants.
- RAM never acks, TIMEOUT = 32 -> err_o pulses exactly once, 32 cycles after RAM stb rises; ram cyc drops; next request is served.
- CPU access to 0x3000_0000 (outside window) -> no RAM activity and no ack; a concurrent generator request is still served.
- Reset asserted while BUS_GEN is active -> all outputs 0 asynchronously; no ack/err after release; first tie after release goes to GEN.
